// File: rtl/cam_pixel_addresser_pkg.sv
// Shared types and default geometry for the camera pixel addresser.
// Package cam_pkg is imported by the top level; it has no logic of its own.
package cam_pkg;

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2
  } cam_addr_state_t;

  localparam int CAM_FRAME_W = 1280;
  localparam int CAM_FRAME_H = 720;

endpackage : cam_pkg

// File: rtl/cam_pixel_addresser_if.sv
// Pixel stream bundle between the byte-pairing stage, the addresser and the frame-buffer writer.
// The slave modport is the addresser's view; the master modport is the environment's view.
interface cam_pixel_addresser_if #(
  parameter int HC_W = 11,
  parameter int VC_W = 10
);

  logic              hs_cam_in;
  logic              vs_cam_in;
  logic [15:0]       data_in;
  logic              valid_in;

  logic [15:0]       pixel_out;
  logic [HC_W-1:0]   hcount_out;
  logic [VC_W-1:0]   vcount_out;
  logic              valid_out;
  logic              frame_start_out;
  logic              frame_done_out;
  logic              err_overrun_out;
  logic [HC_W:0]     line_len_out;
  logic [VC_W:0]     frame_lines_out;
  logic [15:0]       frame_count_out;

  modport master (
    output hs_cam_in, vs_cam_in, data_in, valid_in,
    input  pixel_out, hcount_out, vcount_out, valid_out,
           frame_start_out, frame_done_out, err_overrun_out,
           line_len_out, frame_lines_out, frame_count_out
  );

  modport slave (
    input  hs_cam_in, vs_cam_in, data_in, valid_in,
    output pixel_out, hcount_out, vcount_out, valid_out,
           frame_start_out, frame_done_out, err_overrun_out,
           line_len_out, frame_lines_out, frame_count_out
  );

endinterface : cam_pixel_addresser_if

// File: rtl/sync_edge_det.sv
// Registers a sync level and reports its rising and falling edges against the registered copy.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_rise = i_level & ~r_prev;
  assign o_fall = ~i_level & r_prev;

endmodule : sync_edge_det

// File: rtl/cam_pixel_addresser.sv
// Tags accepted camera pixels with (hcount, vcount) and tracks frame/line boundaries.
// Optional line/frame statistics are built only when CAM_STATS_EN is defined.
module cam_pixel_addresser
  import cam_pkg::*;
#(
  parameter int FRAME_W = CAM_FRAME_W,
  parameter int FRAME_H = CAM_FRAME_H,
  parameter int HC_W    = 11,
  parameter int VC_W    = 10
) (
  input  logic                  clk_pixel_in,
  input  logic                  rst_n_in,
  cam_pixel_addresser_if.slave  bus
);

  // Counters carry one extra bit so FRAME_W == 2**HC_W still compares correctly.
  localparam logic [HC_W:0] LP_W_LIM = FRAME_W[HC_W:0];
  localparam logic [VC_W:0] LP_H_LIM = FRAME_H[VC_W:0];

  cam_addr_state_t  r_state;
  logic [HC_W:0]    r_hcount;
  logic [VC_W:0]    r_vcount;
  logic             r_first_px;

  logic [15:0]      r_pixel;
  logic [HC_W-1:0]  r_hc_out;
  logic [VC_W-1:0]  r_vc_out;
  logic             r_valid;
  logic             r_frame_start;
  logic             r_frame_done;
  logic             r_err_overrun;

  logic w_hs_fall;
  logic w_vs_rise;
  logic w_vs_fall;
  logic w_acc;
  logic w_in_bounds;
  logic w_in_active;
  logic w_line_end;
  logic w_frame_end;
  logic [VC_W:0] w_vcount_next;

  sync_edge_det u_hs_edge (
    .clk     (clk_pixel_in),
    .rst_n   (rst_n_in),
    .i_level (bus.hs_cam_in),
    .o_rise  (),
    .o_fall  (w_hs_fall)
  );

  sync_edge_det u_vs_edge (
    .clk     (clk_pixel_in),
    .rst_n   (rst_n_in),
    .i_level (bus.vs_cam_in),
    .o_rise  (w_vs_rise),
    .o_fall  (w_vs_fall)
  );

  assign w_acc       = bus.valid_in & bus.hs_cam_in & bus.vs_cam_in;
  assign w_in_bounds = (r_hcount < LP_W_LIM) && (r_vcount < LP_H_LIM);
  assign w_in_active = (r_state == ACTIVE);
  // A VSYNC fall absorbs a coincident HSYNC fall, so a line is never counted twice.
  assign w_frame_end = w_in_active & w_vs_fall;
  assign w_line_end  = w_in_active & w_hs_fall & ~w_vs_fall & (r_hcount != '0);
  assign w_vcount_next = (r_vcount < LP_H_LIM) ? r_vcount + 1'b1 : r_vcount;

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state       <= SYNC;
      r_hcount      <= '0;
      r_vcount      <= '0;
      r_first_px    <= 1'b0;
      r_pixel       <= '0;
      r_hc_out      <= '0;
      r_vc_out      <= '0;
      r_valid       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err_overrun <= 1'b0;
    end else begin
      r_valid       <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;

      unique case (r_state)
        // Wait out any frame already in flight when reset was released.
        SYNC: begin
          if (!bus.vs_cam_in) r_state <= VBLANK;
        end

        VBLANK: begin
          if (w_vs_rise) begin
            r_hcount   <= '0;
            r_vcount   <= '0;
            r_first_px <= 1'b1;
            r_state    <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (w_acc) begin
            if (w_in_bounds) begin
              r_valid       <= 1'b1;
              r_pixel       <= bus.data_in;
              r_hc_out      <= r_hcount[HC_W-1:0];
              r_vc_out      <= r_vcount[VC_W-1:0];
              r_hcount      <= r_hcount + 1'b1;
              r_frame_start <= r_first_px;
              r_first_px    <= 1'b0;
            end else begin
              r_err_overrun <= 1'b1;
            end
          end

          if (w_frame_end) begin
            r_frame_done <= 1'b1;
            r_state      <= VBLANK;
          end else if (w_line_end) begin
            r_hcount <= '0;
            r_vcount <= w_vcount_next;
          end
        end

        default: r_state <= SYNC;
      endcase
    end
  end

  assign bus.pixel_out       = r_pixel;
  assign bus.hcount_out      = r_hc_out;
  assign bus.vcount_out      = r_vc_out;
  assign bus.valid_out       = r_valid;
  assign bus.frame_start_out = r_frame_start;
  assign bus.frame_done_out  = r_frame_done;
  assign bus.err_overrun_out = r_err_overrun;

`ifdef CAM_STATS_EN
  logic [HC_W:0] r_line_len;
  logic [VC_W:0] r_frame_lines;
  logic [15:0]   r_frame_count;
  logic          w_partial;

  assign w_partial = (r_hcount != '0);

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_line_len    <= '0;
      r_frame_lines <= '0;
      r_frame_count <= '0;
    end else if (w_frame_end) begin
      // An unterminated last line still counts as a line of the frame.
      r_frame_lines <= r_vcount + (VC_W+1)'(w_partial);
      r_frame_count <= r_frame_count + 1'b1;
      if (w_partial) r_line_len <= r_hcount;
    end else if (w_line_end) begin
      r_line_len <= r_hcount;
    end
  end

  assign bus.line_len_out    = r_line_len;
  assign bus.frame_lines_out = r_frame_lines;
  assign bus.frame_count_out = r_frame_count;
`else
  assign bus.line_len_out    = '0;
  assign bus.frame_lines_out = '0;
  assign bus.frame_count_out = '0;
`endif

endmodule : cam_pixel_addresser

// File: tb/tb_cam_pixel_addresser.sv
// Self-checking bench for cam_pixel_addresser with a small 4x3 frame geometry.
// Expected statistics follow CAM_STATS_EN: model values when defined, zero otherwise.
module tb_cam_pixel_addresser;

  localparam int FW  = 4;
  localparam int FH  = 3;
  localparam int HCW = 3;
  localparam int VCW = 2;

`ifdef CAM_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    bit          fs;
    logic [15:0] d;
    int          h;
    int          v;
  } px_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cam_pixel_addresser_if #(.HC_W(HCW), .VC_W(VCW)) bus ();

  cam_pixel_addresser #(
    .FRAME_W (FW),
    .FRAME_H (FH),
    .HC_W    (HCW),
    .VC_W    (VCW)
  ) dut (
    .clk_pixel_in (clk),
    .rst_n_in     (rst_n),
    .bus          (bus)
  );

  int errors = 0;
  int checks = 0;

  // Observed stream
  px_t obs_q[$];
  int  obs_fd;
  int  obs_stray_fs;

  // Reference model: frame-level rules with plain variables
  px_t exp_q[$];
  int  exp_fd;
  bit  m_synced, m_active, m_hs_p, m_vs_p, m_first, m_err;
  int  m_col, m_row, m_line_len, m_frame_lines, m_fcount;
  logic [15:0] m_last_d;

  bit seq_mode = 1'b0;
  int seq_data = 0;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (bus.valid_out === 1'b1)
        obs_q.push_back('{fs: bus.frame_start_out, d: bus.pixel_out,
                          h: int'(bus.hcount_out), v: int'(bus.vcount_out)});
      if (bus.frame_done_out === 1'b1) obs_fd++;
      if (bus.frame_start_out === 1'b1 && bus.valid_out !== 1'b1) obs_stray_fs++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_synced = 0; m_active = 0; m_hs_p = 0; m_vs_p = 0; m_first = 0; m_err = 0;
    m_col = 0; m_row = 0; m_line_len = 0; m_frame_lines = 0; m_fcount = 0;
  endtask

  task automatic clear_obs();
    obs_q.delete(); exp_q.delete();
    obs_fd = 0; exp_fd = 0; obs_stray_fs = 0;
  endtask

  // One pixel-clock cycle of stimulus, applied to both DUT and model.
  task automatic step(input bit hs, input bit vs, input bit valid);
    logic [15:0] d;
    bit hs_fall, vs_fall, vs_rise;
    d = seq_mode ? seq_data[15:0] : 16'($urandom);
    if (valid && seq_mode) seq_data++;
    bus.hs_cam_in = hs;
    bus.vs_cam_in = vs;
    bus.valid_in  = valid;
    bus.data_in   = d;

    hs_fall = m_hs_p && !hs;
    vs_fall = m_vs_p && !vs;
    vs_rise = !m_vs_p && vs;
    if (!m_synced) begin
      if (!vs) m_synced = 1;
    end else if (!m_active) begin
      if (vs_rise) begin
        m_active = 1; m_col = 0; m_row = 0; m_first = 1;
      end
    end else begin
      if (valid && hs && vs) begin
        if (m_col < FW && m_row < FH) begin
          exp_q.push_back('{fs: m_first, d: d, h: m_col, v: m_row});
          m_last_d = d;
          m_first = 0;
          m_col++;
        end else begin
          m_err = 1;
        end
      end
      if (vs_fall) begin
        exp_fd++;
        m_frame_lines = m_row + ((m_col != 0) ? 1 : 0);
        if (m_col != 0) m_line_len = m_col;
        m_fcount = (m_fcount + 1) % 65536;
        m_active = 0;
      end else if (hs_fall && m_col != 0) begin
        m_line_len = m_col;
        m_col = 0;
        m_row = (m_row < FH) ? m_row + 1 : m_row;
      end
    end
    m_hs_p = hs;
    m_vs_p = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic line_pixels(input int npix);
    for (int i = 0; i < npix; i++) begin
      if ($urandom_range(0, 2) == 0) step(1, 1, 0);
      step(1, 1, 1);
    end
  endtask

  task automatic line(input int npix);
    line_pixels(npix);
    step(0, 1, 0);
    step(0, 1, 0);
  endtask

  task automatic frame_open();
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
  endtask

  task automatic frame_close();
    repeat (3) step(0, 0, 0);
  endtask

  task automatic do_reset();
    bus.hs_cam_in = 0; bus.vs_cam_in = 0; bus.valid_in = 0; bus.data_in = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    clear_obs();
  endtask

  task automatic test_reset();
    bus.hs_cam_in = 0; bus.vs_cam_in = 0; bus.valid_in = 0; bus.data_in = '0;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({bus.valid_out, bus.frame_start_out, bus.frame_done_out, bus.err_overrun_out} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000",
               {bus.valid_out, bus.frame_start_out, bus.frame_done_out, bus.err_overrun_out});
    end
    checks++;
    if ({bus.pixel_out, bus.hcount_out, bus.vcount_out} !== '0) begin
      errors++;
      $display("FAIL reset_pixel: got d=%h h=%0d v=%0d want 0", bus.pixel_out, bus.hcount_out, bus.vcount_out);
    end
    checks++;
    if ({bus.line_len_out, bus.frame_lines_out, bus.frame_count_out} !== '0) begin
      errors++;
      $display("FAIL reset_stats: got %0d %0d %0d want 0", bus.line_len_out, bus.frame_lines_out, bus.frame_count_out);
    end
  endtask

  task automatic test_nominal();
    do_reset();
    seq_mode = 1'b1;
    seq_data = 0;
    frame_open();
    repeat (3) line(4);
    frame_close();
    seq_mode = 1'b0;
    repeat (2) step(0, 0, 0);

    checks++;
    if (obs_q.size() != 12) begin
      errors++;
      $display("FAIL nominal_count: got %0d pixels want 12", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < 12; i++) begin
      checks++;
      if (obs_q[i].d !== 16'(i) || obs_q[i].h != i % 4 || obs_q[i].v != i / 4 || obs_q[i].fs != (i == 0)) begin
        errors++;
        $display("FAIL nominal_px[%0d]: got d=%h (%0d,%0d) fs=%0b want d=%h (%0d,%0d) fs=%0b",
                 i, obs_q[i].d, obs_q[i].h, obs_q[i].v, obs_q[i].fs, 16'(i), i % 4, i / 4, i == 0);
      end
    end
    checks++;
    if (obs_fd != 1) begin
      errors++;
      $display("FAIL nominal_done: got %0d frame_done pulses want 1", obs_fd);
    end
    checks++;
    if (bus.pixel_out !== 16'h000B || bus.hcount_out !== 3'd3 || bus.vcount_out !== 2'd2 || bus.valid_out !== 1'b0) begin
      errors++;
      $display("FAIL nominal_hold: got d=%h (%0d,%0d) v=%b want d=000b (3,2) v=0",
               bus.pixel_out, bus.hcount_out, bus.vcount_out, bus.valid_out);
    end
    checks++;
    if (bus.err_overrun_out !== 1'b0) begin
      errors++;
      $display("FAIL nominal_err: got %b want 0", bus.err_overrun_out);
    end
    checks++;
    if (int'(bus.frame_count_out) != (STATS ? 1 : 0) || int'(bus.line_len_out) != (STATS ? 4 : 0) ||
        int'(bus.frame_lines_out) != (STATS ? 3 : 0)) begin
      errors++;
      $display("FAIL nominal_stats: got count=%0d len=%0d lines=%0d want %0d %0d %0d",
               bus.frame_count_out, bus.line_len_out, bus.frame_lines_out,
               STATS ? 1 : 0, STATS ? 4 : 0, STATS ? 3 : 0);
    end
  endtask

  task automatic test_overrun();
    clear_obs();
    frame_open();
    line(6);
    frame_close();
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL overrun_count: got %0d pixels want 4", obs_q.size());
    end
    checks++;
    if (bus.err_overrun_out !== 1'b1) begin
      errors++;
      $display("FAIL overrun_err: got %b want 1", bus.err_overrun_out);
    end
    checks++;
    if (int'(bus.line_len_out) != (STATS ? 4 : 0) || int'(bus.frame_lines_out) != (STATS ? 1 : 0)) begin
      errors++;
      $display("FAIL overrun_stats: got len=%0d lines=%0d want %0d %0d",
               bus.line_len_out, bus.frame_lines_out, STATS ? 4 : 0, STATS ? 1 : 0);
    end

    clear_obs();
    frame_open();
    repeat (3) line(4);
    frame_close();
    checks++;
    if (bus.err_overrun_out !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b want 1", bus.err_overrun_out);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL overrun_good_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL overrun_good_px[%0d]: got d=%h (%0d,%0d) fs=%0b want d=%h (%0d,%0d) fs=%0b", i,
                 obs_q[i].d, obs_q[i].h, obs_q[i].v, obs_q[i].fs, exp_q[i].d, exp_q[i].h, exp_q[i].v, exp_q[i].fs);
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_obs();
    frame_open();
    line(4);
    step(1, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.valid_out, bus.err_overrun_out, bus.pixel_out, bus.hcount_out, bus.vcount_out} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got v=%b err=%b d=%h (%0d,%0d) want all 0",
               bus.valid_out, bus.err_overrun_out, bus.pixel_out, bus.hcount_out, bus.vcount_out);
    end
    // Release with a frame in full flow.
    bus.hs_cam_in = 1; bus.vs_cam_in = 1; bus.valid_in = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_obs();
    repeat (2) line(4);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_discard: got %0d pixels want 0", obs_q.size());
    end
    frame_close();
    frame_open();
    repeat (2) line(4);
    frame_close();
    checks++;
    if (obs_q.size() != 8 || obs_q[0].h != 0 || obs_q[0].v != 0 || obs_q[0].fs != 1'b1) begin
      errors++;
      $display("FAIL midreset_restart: got n=%0d first=(%0d,%0d) fs=%0b want n=8 (0,0) fs=1", obs_q.size(),
               obs_q.size() ? obs_q[0].h : -1, obs_q.size() ? obs_q[0].v : -1, obs_q.size() ? obs_q[0].fs : 1'b0);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL midreset_px[%0d]: got d=%h (%0d,%0d) want d=%h (%0d,%0d)", i,
                 obs_q[i].d, obs_q[i].h, obs_q[i].v, exp_q[i].d, exp_q[i].h, exp_q[i].v);
      end
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    frame_open();
    repeat (2) line(3);
    line_pixels(1);
    step(0, 0, 0);
    frame_close();
    checks++;
    if (obs_fd != 1 || bus.err_overrun_out !== 1'b0) begin
      errors++;
      $display("FAIL short_done: got done=%0d err=%b want 1 0", obs_fd, bus.err_overrun_out);
    end
    checks++;
    if (obs_q.size() != 7 || obs_q[obs_q.size()-1].h != 0 || obs_q[obs_q.size()-1].v != 2) begin
      errors++;
      $display("FAIL short_pixels: got n=%0d want 7 ending at (0,2)", obs_q.size());
    end
    checks++;
    if (int'(bus.frame_lines_out) != (STATS ? 3 : 0) || int'(bus.line_len_out) != (STATS ? 1 : 0) ||
        int'(bus.frame_count_out) != (STATS ? 1 : 0)) begin
      errors++;
      $display("FAIL short_stats: got lines=%0d len=%0d count=%0d want %0d %0d %0d",
               bus.frame_lines_out, bus.line_len_out, bus.frame_count_out,
               STATS ? 3 : 0, STATS ? 1 : 0, STATS ? 1 : 0);
    end
  endtask

  task automatic test_gated();
    clear_obs();
    frame_open();
    repeat (5) step(0, 1, 1);
    repeat (3) begin
      step(1, 1, 0);
      step(1, 1, 0);
      step(0, 1, 0);
    end
    line(4);
    frame_close();
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL gated_count: got %0d pixels want 4", obs_q.size());
    end
    for (int i = 0; i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].h != i || obs_q[i].v != 0) begin
        errors++;
        $display("FAIL gated_px[%0d]: got (%0d,%0d) want (%0d,0)", i, obs_q[i].h, obs_q[i].v, i);
      end
    end
    checks++;
    if (int'(bus.frame_lines_out) != (STATS ? 1 : 0) || int'(bus.frame_count_out) != (STATS ? 2 : 0)) begin
      errors++;
      $display("FAIL gated_stats: got lines=%0d count=%0d want %0d %0d",
               bus.frame_lines_out, bus.frame_count_out, STATS ? 1 : 0, STATS ? 2 : 0);
    end
  endtask

  task automatic test_random();
    int nl, np;
    clear_obs();
    for (int f = 0; f < 25; f++) begin
      frame_open();
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++) begin
        np = $urandom_range(0, 6);
        if (l == nl - 1 && np > 0 && $urandom_range(0, 1) == 1) begin
          line_pixels(np);
          step(0, 0, 0);
        end else begin
          line(np);
        end
      end
      if ($urandom_range(0, 3) == 0) repeat (2) step(0, 1, 1);
      frame_close();
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL random_px[%0d]: got d=%h (%0d,%0d) fs=%0b want d=%h (%0d,%0d) fs=%0b", i,
                 obs_q[i].d, obs_q[i].h, obs_q[i].v, obs_q[i].fs, exp_q[i].d, exp_q[i].h, exp_q[i].v, exp_q[i].fs);
      end
    end
    checks++;
    if (obs_fd != exp_fd || obs_stray_fs != 0) begin
      errors++;
      $display("FAIL random_events: got done=%0d stray_start=%0d want %0d 0", obs_fd, obs_stray_fs, exp_fd);
    end
    checks++;
    if (bus.err_overrun_out !== m_err) begin
      errors++;
      $display("FAIL random_err: got %b want %b", bus.err_overrun_out, m_err);
    end
    checks++;
    if (exp_q.size() > 0 && bus.pixel_out !== m_last_d) begin
      errors++;
      $display("FAIL random_hold: got %h want %h", bus.pixel_out, m_last_d);
    end
    checks++;
    if (int'(bus.line_len_out) != (STATS ? m_line_len : 0) ||
        int'(bus.frame_lines_out) != (STATS ? m_frame_lines : 0) ||
        int'(bus.frame_count_out) != (STATS ? m_fcount : 0)) begin
      errors++;
      $display("FAIL random_stats: got len=%0d lines=%0d count=%0d want %0d %0d %0d",
               bus.line_len_out, bus.frame_lines_out, bus.frame_count_out,
               STATS ? m_line_len : 0, STATS ? m_frame_lines : 0, STATS ? m_fcount : 0);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overrun();
    test_reset_midframe();
    test_short_frame();
    test_gated();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cam_pixel_addresser

// File: doc/cam_pixel_addresser.md
# cam_pixel_addresser

Downstream of the camera byte-pairing stage: consumes its 16-bit pixel words plus registered HSYNC/VSYNC, in the same `clk_pixel_in` domain. Tracks frame and line boundaries with a small FSM and tags every accepted pixel with its (hcount, vcount) coordinate for frame-buffer write addressing. Discards partial frames after reset and flags geometry violations.

## Interface
Parameters:
- `FRAME_W`, default 1280: active pixels per line.
- `FRAME_H`, default 720: active lines per frame.
- `HC_W`, default 11: hcount width; must satisfy 2^HC_W ≥ FRAME_W.
- `VC_W`, default 10: vcount width; must satisfy 2^VC_W ≥ FRAME_H.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_pixel_in`, input, 1: pixel clock; single clock domain.
  - `rst_n_in`, input, 1: asynchronous, active-low reset.
- Inputs from the byte-pairing stage:
  - `hs_cam_in`, input, 1: registered HSYNC; high during active line.
  - `vs_cam_in`, input, 1: registered VSYNC; high during active frame.
  - `data_in`, input, 16: pixel word.
  - `valid_in`, input, 1: `data_in` holds a complete pixel this cycle.
- Pixel outputs:
  - `pixel_out`, output, 16: accepted pixel.
  - `hcount_out`, output, HC_W: column of `pixel_out`.
  - `vcount_out`, output, VC_W: row of `pixel_out`.
  - `valid_out`, output, 1: pixel/coordinate outputs valid.
- Frame events:
  - `frame_start_out`, output, 1: pulse with pixel (0,0).
  - `frame_done_out`, output, 1: pulse on VSYNC falling edge while ACTIVE.
- Error flags:
  - `err_overrun_out`, output, 1: sticky; a pixel beyond FRAME_W or FRAME_H was dropped.
- Statistics (ports always present):
  - `line_len_out`, output, HC_W+1: pixel count of the last completed line.
  - `frame_lines_out`, output, VC_W+1: line count of the last completed frame.
  - `frame_count_out`, output, 16: completed frames, wrapping.

## Operation
- Accept condition: `acc = valid_in && hs_cam_in && vs_cam_in`.
- Edges come from registered `hs_prev` and `vs_prev`.
- FSM `SYNC → VBLANK → ACTIVE → VBLANK …`
  - **SYNC** (reset state): ignore all input. Move to VBLANK on the first cycle with `vs_cam_in==0`. A frame already in progress at reset is discarded.
  - **VBLANK**: on `vs_cam_in` rising, clear hcount/vcount, set `first_px`, go to ACTIVE.
  - **ACTIVE**:
    - On `acc`:
      - If hcount < FRAME_W and vcount < FRAME_H: emit pixel with the current coordinates, then increment hcount.
      - Otherwise drop the pixel and set `err_overrun_out`.
      - `frame_start_out` accompanies the first emitted pixel while `first_px` is set; that emission clears `first_px`.
    - On HSYNC falling with hcount ≠ 0:
      - Latch `line_len = hcount`.
      - hcount ← 0, vcount ← vcount + 1 (saturates at FRAME_H).
      - An HSYNC fall with hcount = 0 is ignored.
    - On VSYNC falling:
      - Pulse `frame_done_out`; latch `frame_lines`; increment `frame_count`; go to VBLANK.
      - If hcount ≠ 0, that partial line counts toward `frame_lines` (vcount + 1) and latches `line_len`.
- Simultaneous events:
  - `acc` cannot coincide with a VSYNC fall, because `vs_cam_in` is low that cycle.
  - HSYNC fall plus VSYNC fall in the same cycle: single frame-end update, no double count.
- `err_overrun_out` clears only on reset.

## Timing
- All outputs are registered, with 1-cycle latency from `acc` to `valid_out`.
- `pixel_out` and the coordinates hold their value when `valid_out` is low.
- `frame_start_out` and `frame_done_out` are single-cycle pulses.
- No backpressure: the downstream stage must accept every `valid_out`.
- Reset values: every output is 0; the FSM is in SYNC; `hs_prev` = `vs_prev` = 0.
- Reset asserted mid-frame: outputs go to 0 immediately (asynchronous). After release the block returns to SYNC and waits for VSYNC low.

## Configuration
- `CAM_STATS_EN` defined: `line_len_out`, `frame_lines_out` and `frame_count_out` are driven as described in Operation.
- Undefined: those three outputs are tied to 0 and their registers are not built. Pixel, event and error behaviour is identical either way.

## Structure
- Package `cam_pkg` holds:
  - `typedef enum logic [1:0] {SYNC, VBLANK, ACTIVE} cam_addr_state_t`
  - `localparam` defaults `CAM_FRAME_W = 1280` and `CAM_FRAME_H = 720`
- One sub-module, `sync_edge_det`: registers a level and emits rise/fall pulses. Instantiated twice, for HSYNC and VSYNC.

## Test plan
All scenarios use FRAME_W=4, FRAME_H=3 unless stated otherwise.
1. **Nominal frame.** Stimulus: 3 lines of 4 pixels, data 0x0000..0x000B. Required response:
   - 12 `valid_out` pulses with coordinates (0,0)..(3,2).
   - `frame_start_out` with 0x0000; `frame_done_out` on the VSYNC fall.
   - Statistics (`CAM_STATS_EN` defined): `frame_count_out`=1, `line_len_out`=4, `frame_lines_out`=3.
2. **Reset release mid-frame.** Stimulus: release reset with VS=1 and pixels arriving. Required response:
   - No `valid_out` until VSYNC goes low then high.
   - The next frame starts at (0,0).
3. **Line overrun.** Stimulus: one line of 6 pixels. Required response:
   - Pixels 4 and 5 are dropped and `err_overrun_out`=1, sticky through later good frames.
   - Statistics (`CAM_STATS_EN` defined): `line_len_out`=4.
4. **Short frame.** Stimulus: 2 lines of 3 pixels, then VSYNC falls with a partial 3rd line of 1 pixel. Required response:
   - `frame_done_out` pulses and no error is flagged.
   - Statistics (`CAM_STATS_EN` defined): `frame_lines_out`=3, `line_len_out`=1.
5. **Gated valid.** Stimulus: `valid_in` with `hs_cam_in`=0, and spurious HSYNC pulses containing no pixels. Required response:
   - No `valid_out` and no vcount advance.
6. **Macro undefined.** Stimulus: rerun scenario 1 with `CAM_STATS_EN` undefined. Required response:
   - Statistics outputs stay 0; pixel stream identical.
